lpif_ll_credit_link: RTL and testbench

Parametrised logic-link layer for LPIF half-rate slave tops. Replaces the bypass path between the PHY concat block and the user-interface block with a credit-flow-controlled transfer. Upstream words are sent only against credits granted by the far side. Downstream words land in a receive FIFO whose pops are returned to the far side as credits. It sits between `*_concat` and `*_name` inside each generated `*_top`, in the same clock domain as the auto-sync logic.

---
 rtl/lpif_ll_pkg.sv | 45 ++++
 rtl/lpif_ll_sync_fifo.sv | 92 +++++++++
 rtl/lpif_ll_credit_link.sv | 190 +++++++++++++++++++
 tb/tb_lpif_ll_credit_link.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lpif_ll_pkg.sv
// Shared definitions for the LPIF logic-link credit layer: TX state
// encoding, link-word control bit positions and debug_status layout.
package lpif_ll_pkg;

  typedef enum logic {
    OFFLINE = 1'b0,
    ONLINE  = 1'b1
  } tx_state_e;

  // Control bits sit directly above the payload: {credit_rtn, push, data}.
  // Positions are offsets from DATA_WIDTH.
  localparam int LL_PUSH_BIT  = 0;
  localparam int LL_CRTN_BIT  = 1;
  localparam int LL_CTRL_BITS = 2;

  // debug_status field positions
  localparam int DBG_RX_OVF_BIT     = 31;
  localparam int DBG_CREDIT_OVF_BIT = 30;
  localparam int DBG_TX_STATE_BIT   = 29;
  localparam int DBG_RX_ONLINE_BIT  = 28;
  localparam int DBG_CREDIT_LSB     = 8;
  localparam int DBG_OCC_LSB        = 0;
  localparam int DBG_FIELD_W        = 8;

  // Assemble the status word; the unassigned bits [27:16] stay zero.
  function automatic logic [31:0] pack_debug(
    input logic                   rx_ovf,
    input logic                   credit_ovf,
    input logic                   tx_is_online,
    input logic                   rx_is_online,
    input logic [DBG_FIELD_W-1:0] credit,
    input logic [DBG_FIELD_W-1:0] occupancy
  );
    logic [31:0] w;
    w = '0;
    w[DBG_RX_OVF_BIT]     = rx_ovf;
    w[DBG_CREDIT_OVF_BIT] = credit_ovf;
    w[DBG_TX_STATE_BIT]   = tx_is_online;
    w[DBG_RX_ONLINE_BIT]  = rx_is_online;
    w[DBG_CREDIT_LSB +: DBG_FIELD_W] = credit;
    w[DBG_OCC_LSB    +: DBG_FIELD_W] = occupancy;
    return w;
  endfunction

endpackage

// File: rtl/lpif_ll_sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous flush, occupancy output
// and a sticky overflow flag. A push into a full FIFO is dropped unless a
// pop happens in the same cycle, which frees the slot for it.
module lpif_ll_sync_fifo
  import lpif_ll_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 push,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 pop,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 not_empty,
  output logic [CNT_WIDTH-1:0] occupancy,
  output logic                 ovf
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]        LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CNT_WIDTH-1:0] count;
  logic                 ovf_q;
  logic                 pop_ok;
  logic                 push_ok;
  logic                 push_drop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  // Qualify push/pop: flush wins, a full FIFO only accepts alongside a pop.
  always_comb begin
    pop_ok    = pop && (count != '0) && !flush;
    push_ok   = push && !flush && ((count != FULL_CNT) || pop_ok);
    push_drop = push && !flush && !push_ok;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set by any dropped push, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (push_drop) begin
      ovf_q <= 1'b1;
    end
  end

  // Storage array; contents need no reset because reads are gated by count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Show-ahead head; forced to zero while empty so stale data never leaks.
  always_comb begin
    not_empty = (count != '0);
    rd_data   = not_empty ? mem[rd_ptr] : '0;
    occupancy = count;
    ovf       = ovf_q;
  end

endmodule

// File: rtl/lpif_ll_credit_link.sv
// LPIF logic-link layer: credit-flow-controlled TX path and a receive FIFO
// whose pops are returned to the far side as credits.
// Build option: define LPIF_LL_CREDIT_EN for credit flow control; without
// it TX sends whenever online and no credits are tracked or returned.
module lpif_ll_credit_link
  import lpif_ll_pkg::*;
#(
  parameter int DATA_WIDTH   = 1074,
  parameter int DEPTH        = 8,
  parameter int CREDIT_WIDTH = 8
) (
  input  logic                    clk_wr,
  input  logic                    rst_wr_n,
  input  logic                    tx_online,
  input  logic                    rx_online,
  input  logic [CREDIT_WIDTH-1:0] init_upstream_credit,
  input  logic [DATA_WIDTH-1:0]   tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  output logic [DATA_WIDTH+1:0]   tx_link_data,
  input  logic [DATA_WIDTH+1:0]   rx_link_data,
  output logic [DATA_WIDTH-1:0]   rx_data,
  output logic                    rx_valid,
  input  logic                    rx_ready,
  output logic [31:0]             debug_status
);

  localparam int LW     = DATA_WIDTH + LL_CTRL_BITS;
  localparam int PEND_W = 8;

  tx_state_e               state;
  tx_state_e               state_nxt;
  logic [CREDIT_WIDTH-1:0] credit_cnt;
  logic [CREDIT_WIDTH-1:0] credit_cnt_nxt;
  logic [PEND_W-1:0]       credit_pend;
  logic [PEND_W-1:0]       credit_pend_nxt;
  logic                    credit_ovf;
  logic                    credit_ovf_set;
  logic                    emit;
  logic [LW-1:0]           tx_link_q;
  logic                    rx_online_q;
  logic [DATA_WIDTH-1:0]   rx_word;
  logic                    rx_push;
  logic                    rx_crtn;
  logic                    send;
  logic                    pop;
  logic                    rx_ovf;
  logic [DBG_FIELD_W-1:0]  occupancy;
  logic [DBG_FIELD_W-1:0]  credit_dbg;

  assign rx_word = rx_link_data[DATA_WIDTH-1:0];
  assign rx_push = rx_link_data[DATA_WIDTH + LL_PUSH_BIT];
  assign rx_crtn = rx_link_data[DATA_WIDTH + LL_CRTN_BIT];

  assign send = tx_valid && tx_ready;
  assign pop  = rx_valid && rx_ready;

  // TX state register.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      state <= OFFLINE;
    end else begin
      state <= state_nxt;
    end
  end

  // TX next state and send permission; ready only in ONLINE.
  always_comb begin
    state_nxt = state;
    tx_ready  = 1'b0;
    case (state)
      OFFLINE: begin
        if (tx_online) state_nxt = ONLINE;
      end
      ONLINE: begin
`ifdef LPIF_LL_CREDIT_EN
        tx_ready = (credit_cnt != '0);
`else
        tx_ready = 1'b1;
`endif
        if (!tx_online) state_nxt = OFFLINE;
      end
      default: state_nxt = OFFLINE;
    endcase
  end

`ifdef LPIF_LL_CREDIT_EN
  // Credit counter and pending-return bookkeeping.
  always_comb begin
    credit_cnt_nxt  = credit_cnt;
    credit_pend_nxt = credit_pend;
    credit_ovf_set  = 1'b0;
    emit            = (state == ONLINE) && (credit_pend != '0);

    if (state == ONLINE && !tx_online) begin
      credit_pend_nxt = '0;
    end else if (pop && !emit) begin
      credit_pend_nxt = credit_pend + 1'b1;
    end else if (!pop && emit) begin
      credit_pend_nxt = credit_pend - 1'b1;
    end

    if (state == OFFLINE) begin
      if (tx_online) credit_cnt_nxt = init_upstream_credit;
    end else if (!tx_online) begin
      credit_cnt_nxt = '0;
    end else if (rx_crtn && rx_online && !send) begin
      if (&credit_cnt) begin
        credit_ovf_set = 1'b1;
      end else begin
        credit_cnt_nxt = credit_cnt + 1'b1;
      end
    end else if (send && !(rx_crtn && rx_online)) begin
      credit_cnt_nxt = credit_cnt - 1'b1;
    end
  end
`else
  // Bypass flow: credits are neither tracked nor returned.
  logic unused_credit_in;
  assign unused_credit_in = ^{init_upstream_credit, rx_crtn, credit_pend};

  always_comb begin
    credit_cnt_nxt  = '0;
    credit_pend_nxt = '0;
    credit_ovf_set  = 1'b0;
    emit            = 1'b0;
  end
`endif

  // Credit registers and sticky credit overflow.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      credit_cnt  <= '0;
      credit_pend <= '0;
      credit_ovf  <= 1'b0;
    end else begin
      credit_cnt  <= credit_cnt_nxt;
      credit_pend <= credit_pend_nxt;
      if (credit_ovf_set) credit_ovf <= 1'b1;
    end
  end

  // Registered link word: push marks a send, data holds between sends.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_link_q <= '0;
    end else begin
      tx_link_q[DATA_WIDTH + LL_CRTN_BIT] <= emit;
      tx_link_q[DATA_WIDTH + LL_PUSH_BIT] <= send;
      if (send) tx_link_q[DATA_WIDTH-1:0] <= tx_data;
    end
  end

  // Registered copy of rx_online for the status word, so it reads 0 in reset.
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      rx_online_q <= 1'b0;
    end else begin
      rx_online_q <= rx_online;
    end
  end

  lpif_ll_sync_fifo #(
    .WIDTH     (DATA_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (DBG_FIELD_W)
  ) u_rx_fifo (
    .clk       (clk_wr),
    .rst_n     (rst_wr_n),
    .flush     (!rx_online),
    .push      (rx_push && rx_online),
    .wr_data   (rx_word),
    .pop       (pop),
    .rd_data   (rx_data),
    .not_empty (rx_valid),
    .occupancy (occupancy),
    .ovf       (rx_ovf)
  );

  assign tx_link_data = tx_link_q;

  // Status word; credit count zero-extended to its 8-bit field.
  always_comb begin
    credit_dbg = '0;
    credit_dbg[CREDIT_WIDTH-1:0] = credit_cnt;
    debug_status = pack_debug(rx_ovf, credit_ovf, (state == ONLINE),
                              rx_online_q, credit_dbg, occupancy);
  end

endmodule

// File: tb/tb_lpif_ll_credit_link.sv
// Directed self-checking bench for lpif_ll_credit_link (DATA_WIDTH=16,
// DEPTH=8). Follows LPIF_LL_CREDIT_EN to pick the TX-side scenario.
module tb_lpif_ll_credit_link;

  localparam int DW = 16;

`ifdef LPIF_LL_CREDIT_EN
  localparam logic CREDIT_ON = 1'b1;
`else
  localparam logic CREDIT_ON = 1'b0;
`endif

  logic          clk_wr;
  logic          rst_wr_n;
  logic          tx_online;
  logic          rx_online;
  logic [7:0]    init_upstream_credit;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW+1:0] tx_link_data;
  logic [DW+1:0] rx_link_data;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [31:0]   debug_status;

  int checks = 0;
  int errors = 0;

  lpif_ll_credit_link #(
    .DATA_WIDTH   (DW),
    .DEPTH        (8),
    .CREDIT_WIDTH (8)
  ) dut (
    .clk_wr               (clk_wr),
    .rst_wr_n             (rst_wr_n),
    .tx_online            (tx_online),
    .rx_online            (rx_online),
    .init_upstream_credit (init_upstream_credit),
    .tx_data              (tx_data),
    .tx_valid             (tx_valid),
    .tx_ready             (tx_ready),
    .tx_link_data         (tx_link_data),
    .rx_link_data         (rx_link_data),
    .rx_data              (rx_data),
    .rx_valid             (rx_valid),
    .rx_ready             (rx_ready),
    .debug_status         (debug_status)
  );

  initial clk_wr = 1'b0;
  always #5 clk_wr = ~clk_wr;

  function automatic logic [DW+1:0] word(input logic c, input logic p, input int d);
    return {c, p, DW'(d)};
  endfunction

  task automatic tick();
    @(negedge clk_wr);
    #1;
  endtask

  task automatic applyStimulus(input logic txv, input int txd,
                               input logic [DW+1:0] rxl, input logic rxr);
    tx_valid     = txv;
    tx_data      = DW'(txd);
    rx_link_data = rxl;
    rx_ready     = rxr;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_wr_n             = 1'b0;
    tx_online            = 1'b0;
    rx_online            = 1'b1;
    init_upstream_credit = 8'd0;
    applyStimulus(1'b0, 0, '0, 1'b0);
    tick();
    tick();

    $display("[TB] reset values");
    checkOutput("rst_tx_ready", 64'(tx_ready), 64'd0);
    checkOutput("rst_tx_link", 64'(tx_link_data), 64'd0);
    checkOutput("rst_rx_valid", 64'(rx_valid), 64'd0);
    checkOutput("rst_rx_data", 64'(rx_data), 64'd0);
    checkOutput("rst_debug", 64'(debug_status), 64'd0);
    rst_wr_n = 1'b1;

`ifdef LPIF_LL_CREDIT_EN
    $display("[TB] credit-limited send");
    tx_online            = 1'b1;
    init_upstream_credit = 8'd4;
    applyStimulus(1'b1, 'hA000, '0, 1'b0);
    checkOutput("offline_ready", 64'(tx_ready), 64'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      checkOutput("send_ready", 64'(tx_ready), 64'd1);
      checkOutput("send_credit", 64'(debug_status[15:8]), 64'(5 - i));
      if (i > 1) checkOutput("send_word", 64'(tx_link_data), 64'(word(1'b0, 1'b1, 'hA000 + i - 1)));
      applyStimulus(1'b1, 'hA000 + i, '0, 1'b0);
      tick();
    end
    checkOutput("last_word", 64'(tx_link_data), 64'(word(1'b0, 1'b1, 'hA004)));
    checkOutput("exhaust_ready", 64'(tx_ready), 64'd0);
    checkOutput("exhaust_credit", 64'(debug_status[15:8]), 64'd0);
    applyStimulus(1'b1, 'hA005, '0, 1'b0);
    tick();
    checkOutput("idle_word", 64'(tx_link_data), 64'(word(1'b0, 1'b0, 'hA004)));

    $display("[TB] returned credit");
    applyStimulus(1'b1, 'hA005, word(1'b1, 1'b0, 0), 1'b0);
    tick();
    applyStimulus(1'b1, 'hA005, '0, 1'b0);
    checkOutput("rtn_credit", 64'(debug_status[15:8]), 64'd1);
    checkOutput("rtn_ready", 64'(tx_ready), 64'd1);
    tick();
    checkOutput("rtn_word", 64'(tx_link_data), 64'(word(1'b0, 1'b1, 'hA005)));
    checkOutput("rtn_credit0", 64'(debug_status[15:8]), 64'd0);
    checkOutput("rtn_ready0", 64'(tx_ready), 64'd0);

    $display("[TB] send and credit in same cycle");
    applyStimulus(1'b0, 'hA006, word(1'b1, 1'b0, 0), 1'b0);
    tick();
    applyStimulus(1'b1, 'hA006, word(1'b1, 1'b0, 0), 1'b0);
    checkOutput("both_ready", 64'(tx_ready), 64'd1);
    tick();
    applyStimulus(1'b0, 'hA006, '0, 1'b0);
    checkOutput("both_credit", 64'(debug_status[15:8]), 64'd1);
    checkOutput("both_word", 64'(tx_link_data), 64'(word(1'b0, 1'b1, 'hA006)));

    $display("[TB] tx offline and credit overflow");
    tx_online = 1'b0;
    tick();
    checkOutput("off_ready", 64'(tx_ready), 64'd0);
    checkOutput("off_credit", 64'(debug_status[15:8]), 64'd0);
    checkOutput("off_state", 64'(debug_status[29]), 64'd0);
    init_upstream_credit = 8'd255;
    tx_online = 1'b1;
    tick();
    checkOutput("full_credit", 64'(debug_status[15:8]), 64'd255);
    checkOutput("ovf_clear", 64'(debug_status[30]), 64'd0);
    applyStimulus(1'b0, 0, word(1'b1, 1'b0, 0), 1'b0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("ovf_hold", 64'(debug_status[15:8]), 64'd255);
    checkOutput("ovf_set", 64'(debug_status[30]), 64'd1);
`else
    $display("[TB] bypass send");
    tx_online            = 1'b1;
    init_upstream_credit = 8'd0;
    applyStimulus(1'b1, 'hC000, word(1'b1, 1'b0, 0), 1'b0);
    checkOutput("offline_ready", 64'(tx_ready), 64'd0);
    tick();
    for (int i = 1; i <= 3; i++) begin
      checkOutput("byp_ready", 64'(tx_ready), 64'd1);
      if (i > 1) checkOutput("byp_word", 64'(tx_link_data), 64'(word(1'b0, 1'b1, 'hC000 + i - 1)));
      applyStimulus(1'b1, 'hC000 + i, word(1'b1, 1'b0, 0), 1'b0);
      tick();
    end
    checkOutput("byp_last", 64'(tx_link_data), 64'(word(1'b0, 1'b1, 'hC003)));
    checkOutput("byp_credit", 64'(debug_status[15:8]), 64'd0);
    checkOutput("byp_state", 64'(debug_status[29]), 64'd1);
    applyStimulus(1'b0, 'hC004, '0, 1'b0);
    tick();
    checkOutput("byp_idle", 64'(tx_link_data), 64'(word(1'b0, 1'b0, 'hC003)));
    checkOutput("byp_ready_idle", 64'(tx_ready), 64'd1);
`endif

    $display("[TB] rx fill and overflow");
    for (int i = 0; i <= 8; i++) begin
      if (i == 1) begin
        checkOutput("rx_latency_valid", 64'(rx_valid), 64'd1);
        checkOutput("rx_latency_data", 64'(rx_data), 64'hB000);
      end
      if (i == 8) begin
        checkOutput("rx_full_occ", 64'(debug_status[7:0]), 64'd8);
        checkOutput("rx_full_noovf", 64'(debug_status[31]), 64'd0);
      end
      applyStimulus(1'b0, 0, word(1'b0, 1'b1, 'hB000 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("rx_ovf_occ", 64'(debug_status[7:0]), 64'd8);
    checkOutput("rx_ovf_flag", 64'(debug_status[31]), 64'd1);
    checkOutput("rx_head", 64'(rx_data), 64'hB000);

    $display("[TB] pop three and credit return");
    applyStimulus(1'b0, 0, '0, 1'b1);
    tick();
    checkOutput("pop1_data", 64'(rx_data), 64'hB001);
    checkOutput("pop1_crtn", 64'(tx_link_data[DW+1]), 64'd0);
    tick();
    checkOutput("pop2_data", 64'(rx_data), 64'hB002);
    checkOutput("pop2_crtn", 64'(tx_link_data[DW+1]), 64'(CREDIT_ON));
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("pop3_data", 64'(rx_data), 64'hB003);
    checkOutput("pop3_crtn", 64'(tx_link_data[DW+1]), 64'(CREDIT_ON));
    checkOutput("pop3_occ", 64'(debug_status[7:0]), 64'd5);
    tick();
    checkOutput("pop4_crtn", 64'(tx_link_data[DW+1]), 64'(CREDIT_ON));
    tick();
    checkOutput("pop5_crtn", 64'(tx_link_data[DW+1]), 64'd0);

    $display("[TB] drain remaining words");
    applyStimulus(1'b0, 0, '0, 1'b1);
    for (int i = 3; i <= 7; i++) begin
      checkOutput("drain_data", 64'(rx_data), 64'(32'hB000 + i));
      tick();
    end
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("drain_empty", 64'(rx_valid), 64'd0);

    $display("[TB] push while full with pop");
    for (int i = 0; i <= 7; i++) begin
      applyStimulus(1'b0, 0, word(1'b0, 1'b1, 'hF000 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 0, word(1'b0, 1'b1, 'hF008), 1'b1);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("pp_occ", 64'(debug_status[7:0]), 64'd8);
    checkOutput("pp_head", 64'(rx_data), 64'hF001);
    applyStimulus(1'b0, 0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      checkOutput("pp_drain", 64'(rx_data), 64'(32'hF000 + i));
      tick();
    end
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("pp_empty", 64'(rx_valid), 64'd0);

    $display("[TB] rx flush");
    for (int i = 0; i <= 4; i++) begin
      applyStimulus(1'b0, 0, word(1'b0, 1'b1, 'hE000 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("flush_pre_occ", 64'(debug_status[7:0]), 64'd5);
    rx_online = 1'b0;
    tick();
    checkOutput("flush_valid", 64'(rx_valid), 64'd0);
    checkOutput("flush_occ", 64'(debug_status[7:0]), 64'd0);
    checkOutput("flush_rxon", 64'(debug_status[28]), 64'd0);
    applyStimulus(1'b0, 0, word(1'b0, 1'b1, 'hE100), 1'b0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("offline_push", 64'(rx_valid), 64'd0);

    $display("[TB] tx offline");
    tx_online = 1'b0;
    tick();
    checkOutput("txoff_ready", 64'(tx_ready), 64'd0);
    checkOutput("txoff_credit", 64'(debug_status[15:8]), 64'd0);
    checkOutput("txoff_state", 64'(debug_status[29]), 64'd0);

    $display("[TB] reset mid-operation");
    rx_online = 1'b1;
    tx_online = 1'b1;
    applyStimulus(1'b0, 0, word(1'b0, 1'b1, 'hD000), 1'b0);
    tick();
    applyStimulus(1'b1, 'hD001, '0, 1'b0);
    tick();
    applyStimulus(1'b0, 0, '0, 1'b0);
    checkOutput("pre_rst_word", 64'(tx_link_data), 64'(word(1'b0, 1'b1, 'hD001)));
    checkOutput("pre_rst_valid", 64'(rx_valid), 64'd1);
    #2;
    rst_wr_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", 64'(tx_ready), 64'd0);
    checkOutput("mid_rst_link", 64'(tx_link_data), 64'd0);
    checkOutput("mid_rst_valid", 64'(rx_valid), 64'd0);
    checkOutput("mid_rst_data", 64'(rx_data), 64'd0);
    checkOutput("mid_rst_debug", 64'(debug_status), 64'd0);
    tick();
    rst_wr_n = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
